// File: rtl/segre_cache_tag_assoc.sv
// segre_cache_tag_assoc: N-way set-associative tag array with registered lookup, true-LRU victim selection, fills and an invalidate-all sweep
// Ports: clk_i/rsn_i clock and async active-low reset; req_i/addr_i lookup request;
//        fill_i/fill_addr_i tag install; inv_all_i starts the sweep; ready_o accepts req/fill;
//        hit_o/miss_o/hit_way_o/victim_way_o lookup result, valid one cycle after an accepted req
module segre_cache_tag_assoc #(
    parameter int ADDR_SIZE      = 32,
    parameter int NUM_SETS       = 4,
    parameter int NUM_WAYS       = 2,
    parameter int BYTES_PER_LINE = 16,
    localparam int OFF_W = $clog2(BYTES_PER_LINE),
    localparam int IDX_W = $clog2(NUM_SETS),
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int TAG_W = ADDR_SIZE - IDX_W - OFF_W
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 req_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic                 fill_i,
    input  logic [ADDR_SIZE-1:0] fill_addr_i,
    input  logic                 inv_all_i,
    output logic                 ready_o,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic [WAY_W-1:0]     hit_way_o,
    output logic [WAY_W-1:0]     victim_way_o
);
    typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ages_t;
    typedef enum logic {IDLE, FLUSH} state_t;

    function automatic ages_t init_ages();
        ages_t a;
        for (int w = 0; w < NUM_WAYS; w++) a[w] = WAY_W'(w);
        return a;
    endfunction

    localparam ages_t AGE0 = init_ages();

    logic [NUM_SETS-1:0][NUM_WAYS-1:0]            r_valid;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0] r_tag;
    ages_t [NUM_SETS-1:0]                         r_age;
    state_t                                       r_state, w_state_nx;
    logic [IDX_W-1:0]                             r_cnt, w_cnt_nx;

    // Returns {hit, hit way, victim way}; victim is the lowest invalid way, else the LRU way
    function automatic logic [2*WAY_W:0] probe(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
        logic             hit;
        logic [WAY_W-1:0] way, vic;
        hit = 1'b0;
        way = '0;
        vic = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[idx][w] && r_tag[idx][w] == tag) begin
                hit = 1'b1;
                way = WAY_W'(w);
            end
            if (r_age[idx][w] == WAY_W'(NUM_WAYS - 1)) vic = WAY_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) if (!r_valid[idx][w]) vic = WAY_W'(w);
        return {hit, way, vic};
    endfunction

    // Make 'way' MRU: younger ways age by one, older ways keep their age
    function automatic ages_t touch(input ages_t a, input logic [WAY_W-1:0] way);
        ages_t t;
        for (int w = 0; w < NUM_WAYS; w++)
            t[w] = (WAY_W'(w) == way) ? '0 : (a[w] < a[way] ? a[w] + 1'b1 : a[w]);
        return t;
    endfunction

    logic [IDX_W-1:0] w_lidx, w_fidx;
    logic [TAG_W-1:0] w_ltag, w_ftag;
    logic             w_lhit, w_fhit, w_req, w_fill, w_lupd;
    logic [WAY_W-1:0] w_lway, w_lvic, w_fhway, w_fvic, w_fway;
    ages_t            w_lage, w_fage;

    assign ready_o = (r_state == IDLE);
    assign w_req   = ready_o & req_i & ~inv_all_i;
    assign w_fill  = ready_o & fill_i & ~inv_all_i;
    assign w_lidx  = addr_i[IDX_W+OFF_W-1:OFF_W];
    assign w_ltag  = addr_i[ADDR_SIZE-1:IDX_W+OFF_W];
    assign w_fidx  = fill_addr_i[IDX_W+OFF_W-1:OFF_W];
    assign w_ftag  = fill_addr_i[ADDR_SIZE-1:IDX_W+OFF_W];
    assign {w_lhit, w_lway, w_lvic} = probe(w_lidx, w_ltag);
    assign {w_fhit, w_fhway, w_fvic} = probe(w_fidx, w_ftag);
    // A fill whose tag is already present refreshes that way instead of allocating a duplicate
    assign w_fway  = w_fhit ? w_fhway : w_fvic;
    // In the same set the fill's recency update takes precedence over the hit's
    assign w_lupd  = w_req & w_lhit & ~(w_fill & (w_fidx == w_lidx));
    assign w_fage  = touch(r_age[w_fidx], w_fway);
    assign w_lage  = touch(r_age[w_lidx], w_lway);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (r_state == IDLE) begin
            w_state_nx = inv_all_i ? FLUSH : IDLE;
            w_cnt_nx   = '0;
        end else begin
            w_cnt_nx   = r_cnt + 1'b1;
            w_state_nx = (r_cnt == IDX_W'(NUM_SETS - 1)) ? IDLE : FLUSH;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_valid      <= '0;
            r_tag        <= '0;
            r_age        <= {NUM_SETS{AGE0}};
            hit_o        <= 1'b0;
            miss_o       <= 1'b0;
            hit_way_o    <= '0;
            victim_way_o <= '0;
        end else begin
            hit_o        <= w_req & w_lhit;
            miss_o       <= w_req & ~w_lhit;
            hit_way_o    <= (w_req & w_lhit) ? w_lway : '0;
            victim_way_o <= w_req ? w_lvic : '0;
            if (r_state == FLUSH) begin
                r_valid[r_cnt] <= '0;
                r_age[r_cnt]   <= AGE0;
            end
            if (w_fill) begin
                r_valid[w_fidx][w_fway] <= 1'b1;
                r_tag[w_fidx][w_fway]   <= w_ftag;
                r_age[w_fidx]           <= w_fage;
            end
            if (w_lupd) r_age[w_lidx] <= w_lage;
        end
    end
endmodule

// File: tb/tb_segre_cache_tag_assoc.sv
// tb_segre_cache_tag_assoc: directed vector table plus reset-during-sweep sequence for the tag array
module tb_segre_cache_tag_assoc;
    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        fill_i = 1'b0;
    logic [31:0] fill_addr_i = '0;
    logic        inv_all_i = 1'b0;
    logic        ready_o, hit_o, miss_o;
    logic        hit_way_o, victim_way_o;

    int checks = 0;
    int failures = 0;

    segre_cache_tag_assoc dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .req_i(req_i), .addr_i(addr_i),
        .fill_i(fill_i), .fill_addr_i(fill_addr_i), .inv_all_i(inv_all_i),
        .ready_o(ready_o), .hit_o(hit_o), .miss_o(miss_o),
        .hit_way_o(hit_way_o), .victim_way_o(victim_way_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        fill;
        logic [31:0] faddr;
        logic        inv;
        logic [4:0]  exp;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic req, logic [31:0] addr, logic fill, logic [31:0] faddr,
                                logic inv, logic hit, logic miss, logic hway, logic vic, logic rdy);
        vec_t v;
        v.req = req; v.addr = addr; v.fill = fill; v.faddr = faddr; v.inv = inv;
        v.exp = {hit, miss, hway, vic, rdy};
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [4:0] req);
        logic [4:0] act;
        act = {hit_o, miss_o, hit_way_o, victim_way_o, ready_o};
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: {hit,miss,hit_way,victim,ready} actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic fill,
                         input logic [31:0] faddr, input logic inv);
        req_i = req; addr_i = addr; fill_i = fill; fill_addr_i = faddr; inv_all_i = inv;
        @(posedge clk_i);
        #1;
        req_i = 1'b0; fill_i = 1'b0; inv_all_i = 1'b0;
    endtask

    initial begin
        //  req addr          fill faddr         inv  hit miss hw vic rdy
        add(1, 32'h0000_0040, 0, 32'h0,          0,   0,  1,   0, 0,  1);
        add(0, 32'h0,         1, 32'h0000_0040,  0,   0,  0,   0, 0,  1);
        add(1, 32'h0000_0044, 0, 32'h0,          0,   1,  0,   0, 1,  1);
        add(1, 32'h0000_0140, 0, 32'h0,          0,   0,  1,   0, 1,  1);
        add(0, 32'h0,         1, 32'h0000_0140,  0,   0,  0,   0, 0,  1);
        add(1, 32'h0000_0040, 0, 32'h0,          0,   1,  0,   0, 0,  1);
        add(0, 32'h0,         1, 32'h0000_0240,  0,   0,  0,   0, 0,  1);
        add(1, 32'h0000_0140, 0, 32'h0,          0,   0,  1,   0, 0,  1);
        add(1, 32'h0000_0040, 0, 32'h0,          0,   1,  0,   0, 0,  1);
        add(1, 32'h0000_0050, 1, 32'h0000_0050,  0,   0,  1,   0, 0,  1);
        add(1, 32'h0000_0050, 0, 32'h0,          0,   1,  0,   0, 1,  1);
        add(0, 32'h0,         1, 32'h0000_0050,  0,   0,  0,   0, 0,  1);
        add(1, 32'h0000_0150, 0, 32'h0,          0,   0,  1,   0, 1,  1);
        add(1, 32'h0000_0240, 1, 32'h0000_0040,  0,   1,  0,   1, 1,  1);
        add(1, 32'h0000_0340, 0, 32'h0,          0,   0,  1,   0, 1,  1);
        add(0, 32'h0,         1, 32'h0000_0060,  0,   0,  0,   0, 0,  1);
        add(0, 32'h0,         1, 32'h0000_0070,  0,   0,  0,   0, 0,  1);
        add(1, 32'h0000_0060, 0, 32'h0,          0,   1,  0,   0, 1,  1);
        add(1, 32'h0000_0040, 0, 32'h0,          1,   0,  0,   0, 0,  0);
        add(1, 32'h0000_0040, 0, 32'h0,          0,   0,  0,   0, 0,  0);
        add(1, 32'h0000_0040, 1, 32'h0000_0140,  0,   0,  0,   0, 0,  0);
        add(1, 32'h0000_0050, 0, 32'h0,          1,   0,  0,   0, 0,  0);
        add(1, 32'h0000_0040, 0, 32'h0,          0,   0,  0,   0, 0,  1);
        add(1, 32'h0000_0040, 0, 32'h0,          0,   0,  1,   0, 0,  1);
        add(1, 32'h0000_0140, 0, 32'h0,          0,   0,  1,   0, 0,  1);
        add(1, 32'h0000_0050, 0, 32'h0,          0,   0,  1,   0, 0,  1);
        add(1, 32'h0000_0060, 0, 32'h0,          0,   0,  1,   0, 0,  1);
        add(1, 32'h0000_0070, 0, 32'h0,          0,   0,  1,   0, 0,  1);

        #2;
        check("reset_state", 5'b00001);
        @(posedge clk_i);
        #1;
        check("reset_held_edge", 5'b00001);
        rsn_i = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].req, vq[i].addr, vq[i].fill, vq[i].faddr, vq[i].inv);
            check($sformatf("vec%0d", i), vq[i].exp);
        end

        drive(0, 32'h0, 1, 32'h0000_0040, 0);
        check("mf_fill", 5'b00001);
        drive(1, 32'h0000_0040, 0, 32'h0, 0);
        check("mf_hit_before_flush", 5'b10011);
        drive(0, 32'h0, 0, 32'h0, 1);
        check("mf_flush_c1", 5'b00000);
        drive(0, 32'h0, 0, 32'h0, 0);
        check("mf_flush_c2", 5'b00000);
        #3;
        rsn_i = 1'b0;
        #1;
        check("mf_async_reset", 5'b00001);
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        check("mf_after_release", 5'b00001);
        drive(1, 32'h0000_0040, 0, 32'h0, 0);
        check("mf_req_after_reset", 5'b01001);
        drive(0, 32'h0, 0, 32'h0, 0);
        check("mf_idle_after_req", 5'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
